fsqrt_pipe: RTL

//  Parametrised, fully pipelined IEEE-754 single-precision square root for the FPU.

---
 rtl/fsqrt_pipe.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/fsqrt_pipe.sv
// fsqrt_pipe: pipelined IEEE-754 single-precision square root (unpack -> NSTAGE restoring stages -> round/pack).
// Define FSQRT_FLAGS_EN to add the registered out_flags {invalid,inexact} port.

module fsqrt_stage #(
  parameter int FIRST = 0,
  parameter int CNT   = 5
) (
  input  logic [49:0] rad,
  input  logic [26:0] rem,
  input  logic [24:0] root,
  output logic [26:0] nxt_rem,
  output logic [24:0] nxt_root
);
  logic [28:0] r, t;
  logic [24:0] q;
  logic [49:0] rs;

  // Each root bit consumes the next two radicand bits, MSB first.
  always_comb begin
    r  = {2'b00, rem};
    q  = root;
    t  = '0;
    rs = rad << (2 * FIRST);
    for (int j = 0; j < CNT; j++) begin
      r  = {r[26:0], rs[49:48]};
      rs = rs << 2;
      t  = {2'b00, q, 2'b01};
      if (r >= t) begin
        r = r - t;
        q = {q[23:0], 1'b1};
      end else begin
        q = {q[23:0], 1'b0};
      end
    end
    nxt_rem  = r[26:0];
    nxt_root = q;
  end
endmodule

module fsqrt_pipe #(
  parameter int BITS_PER_STAGE = 5,
  parameter int TAG_W          = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag
`ifdef FSQRT_FLAGS_EN
  ,
  output logic [1:0]       out_flags
`endif
);
  localparam int NSTAGE = (25 + BITS_PER_STAGE - 1) / BITS_PER_STAGE;
  localparam int STAGES = NSTAGE + 1;

  typedef struct packed {
    logic             sp;
    logic [31:0]      forced;
`ifdef FSQRT_FLAGS_EN
    logic             inv;
`endif
    logic [7:0]       exp;
    logic [49:0]      rad;
    logic [26:0]      rem;
    logic [24:0]      root;
    logic [TAG_W-1:0] tag;
  } stg_t;

  // vld_pipe[0] tracks st[0], vld_pipe[k] tracks st[k], vld_pipe[STAGES] is out_valid.
  logic [STAGES:0] vld_pipe;
  stg_t            st [NSTAGE+1];
  stg_t            unp;
  logic [26:0]     nrem  [NSTAGE];
  logic [24:0]     nroot [NSTAGE];
  logic            en;
  logic [7:0]      e_in;
  logic [22:0]     m_in;

  assign en        = ~(out_valid & ~out_ready);
  assign in_ready  = rstn & en;
  assign out_valid = vld_pipe[STAGES];
  assign e_in      = in_data[30:23];
  assign m_in      = in_data[22:0];

  always_comb begin
    unp     = '0;
    unp.tag = in_tag;
    unp.exp = 8'(({1'b0, e_in} + 9'd127) >> 1);
    // E even means unbiased exponent odd: radicand doubled into [2,4).
    unp.rad = in_data[23] ? {2'b01, m_in, 25'd0} : {1'b1, m_in, 26'd0};
    if (e_in == 8'hFF && m_in != '0) begin
      unp.sp = 1'b1; unp.forced = 32'h7FC00000;
    end else if (e_in == 8'h00) begin
      unp.sp = 1'b1; unp.forced = {in_data[31], 31'd0};
    end else if (in_data[31]) begin
      unp.sp = 1'b1; unp.forced = 32'h7FC00000;
    end else if (e_in == 8'hFF) begin
      unp.sp = 1'b1; unp.forced = 32'h7F800000;
    end
`ifdef FSQRT_FLAGS_EN
    unp.inv = (e_in == 8'hFF && m_in != '0) || (in_data[31] && e_in != 8'h00);
`endif
  end

  for (genvar s = 0; s < NSTAGE; s++) begin : g_stage
    localparam int FIRST = s * BITS_PER_STAGE;
    localparam int CNT   = (25 - FIRST < BITS_PER_STAGE) ? 25 - FIRST : BITS_PER_STAGE;
    fsqrt_stage #(.FIRST(FIRST), .CNT(CNT)) u_stage (
      .rad      (st[s].rad),
      .rem      (st[s].rem),
      .root     (st[s].root),
      .nxt_rem  (nrem[s]),
      .nxt_root (nroot[s])
    );
  end

  logic        grd, stk, inc;
  logic [23:0] frac;
  logic [31:0] pack;

  // root[24] is the hidden one; a carry out of frac bumps the exponent and leaves mantissa 0.
  always_comb begin
    grd  = st[NSTAGE].root[0];
    stk  = |st[NSTAGE].rem;
    inc  = grd & (stk | st[NSTAGE].root[1]);
    frac = {1'b0, st[NSTAGE].root[23:1]} + {23'd0, inc};
    if (st[NSTAGE].sp) pack = st[NSTAGE].forced;
    else               pack = {1'b0, st[NSTAGE].exp + {7'd0, frac[23]}, frac[22:0]};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_pipe <= '0;
      out_data <= '0;
      out_tag  <= '0;
`ifdef FSQRT_FLAGS_EN
      out_flags <= '0;
`endif
    end else if (en) begin
      vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
      out_data <= pack;
      out_tag  <= st[NSTAGE].tag;
`ifdef FSQRT_FLAGS_EN
      out_flags <= {st[NSTAGE].inv, ~st[NSTAGE].sp & (grd | stk)};
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      st[0] <= unp;
      for (int k = 1; k <= NSTAGE; k++) begin
        st[k]      <= st[k-1];
        st[k].rem  <= nrem[k-1];
        st[k].root <= nroot[k-1];
      end
    end
  end
endmodule
